// File: rtl/icache_nway.sv
// icache_nway: read-only N-way set-associative instruction cache with tree PLRU
// replacement, single-cycle flush and saturating hit/miss counters.
module icache_nway #(
   parameter int WAYS       = 2,
   parameter int SETS       = 8,
   parameter int LINE_BYTES = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      read_a,
   input  logic [31:0]               address_a,
   output logic [31:0]               rdata_a,
   output logic                      resp_a,
   input  logic                      flush,
   output logic                      pmem_read_a,
   output logic [31:0]               pmem_addr_a,
   input  logic                      pmem_resp_a,
   input  logic [8*LINE_BYTES-1:0]   pmem_rdata_a,
   output logic [31:0]               hit_count,
   output logic [31:0]               miss_count
);
   localparam int LINE_BITS = 8 * LINE_BYTES;
   localparam int OFF       = $clog2(LINE_BYTES);
   localparam int IDX       = $clog2(SETS);
   localparam int TAG       = 32 - OFF - IDX;
   localparam int WB        = $clog2(WAYS);
   localparam int NODES     = WAYS - 1;

   typedef enum logic [1:0] {IDLE, FETCH, INSTALL} state_t;
   state_t r_state, w_next;

   logic [LINE_BITS-1:0] r_data  [WAYS][SETS];
   logic [TAG-1:0]       r_tag   [WAYS][SETS];
   logic [SETS-1:0]      r_valid [WAYS];
   logic [NODES-1:0]     r_plru  [SETS];
   logic [TAG+IDX-1:0]   r_line;
   logic [WB-1:0]        r_victim;
   logic                 r_flushed;
   logic                 r_retry;
   logic [31:0]          r_hits;
   logic [31:0]          r_misses;

   logic [IDX-1:0]       w_idx;
   logic [IDX-1:0]       w_ridx;
   logic [TAG-1:0]       w_tag;
   logic [OFF-3:0]       w_wsel;
   logic                 w_hit_any;
   logic                 w_any_inv;
   logic                 w_hit;
   logic                 w_miss;
   logic [WB-1:0]        w_hit_way;
   logic [WB-1:0]        w_inv_way;
   logic [WB-1:0]        w_victim;
   logic [LINE_BITS-1:0] w_line;
   logic                 w_unused;

   // Way w sits under the tree with w[0] choosing at the root, w[1] at the next level, ...
   function automatic logic [WB-1:0] plru_victim(input logic [NODES-1:0] t);
      int   n;
      logic b;
      n = 0;
      plru_victim = '0;
      for (int l = 0; l < WB; l++) begin
         b = 1'b0;
         for (int k = 0; k < NODES; k++) if (k == n) b = t[k];
         plru_victim[l] = b;
         n = 2 * n + (b ? 2 : 1);
      end
   endfunction

   function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] t, input logic [WB-1:0] w);
      int n;
      n = 0;
      plru_touch = t;
      for (int l = 0; l < WB; l++) begin
         for (int k = 0; k < NODES; k++) if (k == n) plru_touch[k] = ~w[l];
         n = 2 * n + (w[l] ? 2 : 1);
      end
   endfunction

   assign w_idx       = address_a[OFF+IDX-1:OFF];
   assign w_tag       = address_a[31:OFF+IDX];
   assign w_wsel      = address_a[OFF-1:2];
   assign w_unused    = ^address_a[1:0];
   assign w_ridx      = r_line[IDX-1:0];
   assign w_line      = r_data[w_hit_way][w_idx];
   assign w_hit       = r_state == IDLE && read_a && w_hit_any;
   assign w_miss      = r_state == IDLE && read_a && !w_hit_any;
   assign resp_a      = w_hit;
   assign rdata_a     = w_line[{w_wsel, 5'd0} +: 32];
   assign pmem_read_a = r_state == FETCH;
   assign pmem_addr_a = {r_line, {OFF{1'b0}}};
   assign hit_count   = r_hits;
   assign miss_count  = r_misses;

   always_comb begin
      w_hit_any = 1'b0;
      w_hit_way = '0;
      for (int w = WAYS - 1; w >= 0; w--)
         if (r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
            w_hit_any = 1'b1;
            w_hit_way = WB'(w);
         end
   end

   // Lowest-index invalid way takes priority over the PLRU choice.
   always_comb begin
      w_any_inv = 1'b0;
      w_inv_way = '0;
      for (int w = WAYS - 1; w >= 0; w--)
         if (!r_valid[w][w_ridx]) begin
            w_any_inv = 1'b1;
            w_inv_way = WB'(w);
         end
      w_victim = w_any_inv ? w_inv_way : plru_victim(r_plru[w_ridx]);
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_miss ? FETCH : IDLE;
         FETCH:   w_next = pmem_resp_a ? INSTALL : FETCH;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;

   always_ff @(posedge clk) if (r_state == FETCH && pmem_resp_a) r_data[w_victim][w_ridx] <= pmem_rdata_a;

   // r_retry marks a held request that already counted as a miss, so its final hit is not counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
         for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
         r_hits    <= '0;
         r_misses  <= '0;
         r_retry   <= 1'b0;
         r_flushed <= 1'b0;
      end else begin
         r_retry <= r_state == IDLE ? w_miss : r_retry && read_a;
         if (w_miss) begin
            r_line    <= {w_tag, w_idx};
            r_flushed <= 1'b0;
            if (r_misses != '1) r_misses <= r_misses + 1;
         end
         if (w_hit) begin
            r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_hit_way);
            if (!r_retry && r_hits != '1) r_hits <= r_hits + 1;
         end
         if (r_state == FETCH && flush) r_flushed <= 1'b1;
         if (r_state == FETCH && pmem_resp_a) begin
            r_victim                <= w_victim;
            r_tag[w_victim][w_ridx] <= r_line[TAG+IDX-1:IDX];
         end
         if (r_state == INSTALL) begin
            r_plru[w_ridx] <= plru_touch(r_plru[w_ridx], r_victim);
            if (!r_flushed) r_valid[r_victim][w_ridx] <= 1'b1;
         end
         if (flush) for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
      end
   end
endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: directed checks of icache_nway with a 2-way and a 4-way instance,
// each served by its own fixed-latency memory model.
module tb_icache_nway;
   localparam int          LAT = 3;
   localparam logic [31:0] K   = 32'hC0DE_0000;

   logic         clk   = 1'b0;
   logic         rst   = 1'b1;
   logic         flush = 1'b0;
   logic [1:0]   rq    = '0;
   logic [1:0]   inj   = '0;
   logic [1:0]   resp;
   logic [1:0]   pmr;
   logic [1:0]   presp;
   logic [31:0]  addr  = '0;
   logic [31:0]  rdata [2];
   logic [31:0]  pa    [2];
   logic [31:0]  hc    [2];
   logic [31:0]  mc    [2];
   logic [255:0] pline [2];
   int           lat     [2] = '{0, 0};
   int           fetches [2] = '{0, 0};
   int           n_tests = 0;
   int           n_fail  = 0;
   logic         pr1;
   logic [31:0]  pa1;

   always #5 clk = ~clk;

   icache_nway #(.WAYS(2), .SETS(8), .LINE_BYTES(32)) u0 (
      .clk(clk), .rst(rst), .read_a(rq[0]), .address_a(addr), .rdata_a(rdata[0]), .resp_a(resp[0]),
      .flush(flush), .pmem_read_a(pmr[0]), .pmem_addr_a(pa[0]), .pmem_resp_a(presp[0] | inj[0]),
      .pmem_rdata_a(pline[0]), .hit_count(hc[0]), .miss_count(mc[0]));

   icache_nway #(.WAYS(4), .SETS(8), .LINE_BYTES(32)) u1 (
      .clk(clk), .rst(rst), .read_a(rq[1]), .address_a(addr), .rdata_a(rdata[1]), .resp_a(resp[1]),
      .flush(flush), .pmem_read_a(pmr[1]), .pmem_addr_a(pa[1]), .pmem_resp_a(presp[1] | inj[1]),
      .pmem_rdata_a(pline[1]), .hit_count(hc[1]), .miss_count(mc[1]));

   function automatic logic [255:0] mkline(input logic [31:0] a);
      for (int i = 0; i < 8; i++) mkline[32*i +: 32] = (a + 32'(4 * i)) ^ K;
   endfunction

   always @(posedge clk)
      for (int k = 0; k < 2; k++) begin
         presp[k] <= 1'b0;
         if (pmr[k] && !presp[k] && lat[k] == LAT - 1) begin
            presp[k]   <= 1'b1;
            pline[k]   <= mkline(pa[k]);
            fetches[k] <= fetches[k] + 1;
            lat[k]     <= 0;
         end else lat[k] <= (pmr[k] && !presp[k]) ? lat[k] + 1 : 0;
      end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic rd(input int k, input logic [31:0] a, output int cyc, output logic [31:0] d);
      cyc   = 0;
      addr  = a;
      rq[k] = 1'b1;
      #1;
      while (!resp[k] && cyc < 100) begin
         @(negedge clk);
         #1;
         cyc++;
         if (cyc == 1) begin
            pr1 = pmr[k];
            pa1 = pa[k];
         end
      end
      d = rdata[k];
      if (cyc >= 100) check("timeout", resp[k], 1);
      @(negedge clk);
      rq[k] = 1'b0;
   endtask

   task automatic rdchk(input string tag, input int k, input logic [31:0] a, input int exp_cyc);
      int          cyc;
      logic [31:0] d;
      rd(k, a, cyc, d);
      check({tag, "_lat"}, cyc, exp_cyc);
      check({tag, "_data"}, d, {a[31:2], 2'b00} ^ K);
   endtask

   initial begin
      int f0;
      repeat (2) @(negedge clk);
      check("rst_resp", resp[0], 0);
      check("rst_pmem_read", pmr[0], 0);
      check("rst_hits", hc[0], 0);
      check("rst_misses", mc[0], 0);
      rst = 1'b0;
      rdchk("t1_miss", 0, 32'h40, LAT + 3);
      check("t1_pmem_read", pr1, 1);
      check("t1_pmem_addr", pa1, 32'h40);
      check("t1_misses", mc[0], 1);
      check("t1_hits", hc[0], 0);
      rdchk("t2_w1", 0, 32'h44, 0);
      rdchk("t2_w7", 0, 32'h5C, 0);
      check("t2_hits", hc[0], 2);
      check("t2_fetches", fetches[0], 1);
      rdchk("t3_a0", 0, 32'h000, LAT + 3);
      rdchk("t3_a1", 0, 32'h100, LAT + 3);
      rdchk("t3_touch", 0, 32'h000, 0);
      rdchk("t3_a2", 0, 32'h200, LAT + 3);
      rdchk("t3_keep", 0, 32'h000, 0);
      rdchk("t3_evicted", 0, 32'h100, LAT + 3);
      for (int i = 0; i < 4; i++) rdchk("t4_fill", 1, 32'(i << 8), LAT + 3);
      for (int i = 0; i < 3; i++) rdchk("t4_touch", 1, 32'(i << 8), 0);
      rdchk("t4_fifth", 1, 32'h400, LAT + 3);
      for (int i = 0; i < 3; i++) rdchk("t4_kept", 1, 32'(i << 8), 0);
      rdchk("t4_fifth_hit", 1, 32'h400, 0);
      rdchk("t4_way3_evicted", 1, 32'h300, LAT + 3);
      f0 = fetches[0];
      fork
         rdchk("t5_refetch", 0, 32'h80, 2 * LAT + 6);
         begin
            repeat (2) @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
         end
      join
      check("t5_fetches", fetches[0] - f0, 2);
      rdchk("t5_hit", 0, 32'h80, 0);
      flush = 1'b1;
      rdchk("t5_flush_hit", 0, 32'h80, 0);
      flush = 1'b0;
      rdchk("t5_after_flush", 0, 32'h80, LAT + 3);
      addr  = 32'h60;
      rq[0] = 1'b1;
      @(negedge clk);
      check("t6_fetching", pmr[0], 1);
      rst   = 1'b1;
      rq[0] = 1'b0;
      @(negedge clk);
      check("t6_pmem_read_drop", pmr[0], 0);
      rst    = 1'b0;
      inj[0] = 1'b1;
      @(negedge clk);
      inj[0] = 1'b0;
      check("t6_stale_ignored", pmr[0], 0);
      check("t6_hits", hc[0], 0);
      check("t6_misses", mc[0], 0);
      @(negedge clk);
      check("t6_idle_resp", resp[0], 0);
      rdchk("t6_miss_60", 0, 32'h60, LAT + 3);
      rdchk("t6_miss_44", 0, 32'h44, LAT + 3);
      check("t6_misses_after", mc[0], 2);
      check("t6_hits_after", hc[0], 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
